display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexes the single shared 4-bit-to-seven-segment decoder across a bank of common-cathode digits. Holds a shadow and an active copy of every digit code and scans the active copy at a fixed dwell, with blanking gaps between digits to suppress ghosting. Shadow-to-active transfer is synchronised to frame boundaries so a multi-digit update never tears. Sits between the host register interface and the decoder/pad drivers.

## Interface
- `DIGITS`, 4: number of digits scanned, 2..8
- `DWELL`, 1000: cycles a digit is lit, ≥1
- `BLANK`, 16: all-off cycles before each digit, ≥0
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `enable` in 1: scanning on when high
- `wr_en` in 1: write `wr_data` into shadow slot `wr_addr`
- `wr_addr` in clog2(DIGITS): shadow slot index
- `wr_data` in 4: digit code
- `commit` in 1: one-cycle request to transfer shadow to active
- `commit_ack` out 1: one-cycle pulse when the transfer happens
- `code` out 4: code presented to the decoder
- `seg_en` out 1: segment enable, ANDed with decoder outputs at top level
- `digit_sel` out DIGITS: one-hot digit drive, active high
- `frame_start` out 1: one-cycle pulse on first lit cycle of digit 0

## Operation
- States: OFF, BLANK, SHOW. Digit index `idx` runs 0..DIGITS-1. Cycle counter is wide enough for max(DWELL, BLANK).
- OFF: `digit_sel`=0, `seg_en`=0, `idx`=0. Stays in OFF while `enable`=0. `enable`=1 → BLANK, counter 0.
- BLANK: `digit_sel`=0, `seg_en`=0, `code`=active[idx]. After BLANK cycles → SHOW. BLANK=0 skips the state entirely.
- SHOW: `digit_sel`=one-hot(idx), `seg_en`=1, `code`=active[idx]. After DWELL cycles, `idx` advances with wrap DIGITS-1→0, then → BLANK.
- `enable`=0 in any state → OFF at the next edge, mid-dwell included. Re-enable restarts at digit 0 with a full BLANK.
- Writes: a `wr_en` with `wr_addr` < DIGITS updates that shadow slot at the edge. `wr_addr` ≥ DIGITS is ignored. Writes never touch the active copy directly.
- Commit: `commit` sets `pending`. A repeat `commit` while `pending` is set is absorbed, giving one ack.
- Transfer happens when `pending` is set and either:
  - the scanner is in OFF, or
  - the edge that wraps `idx` to 0.
- At transfer: active ← shadow, `pending` cleared, `commit_ack` pulses for one cycle.
- If a write and a transfer share an edge, the transfer copies the pre-write shadow value. The write lands in shadow only and waits for the next commit.
- A `commit` on the same edge as a transfer sets `pending` again.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Reset values:
  - state OFF, `idx`=0, `pending`=0
  - all shadow and active slots 0
  - `code`=0, `seg_en`=0, `digit_sel`=0, `commit_ack`=0, `frame_start`=0
- `enable` sampled high at edge k: BLANK from k+1 for BLANK cycles, then digit 0 lit for DWELL cycles.
- Frame period is DIGITS×(BLANK+DWELL) cycles. `frame_start` occurs once per frame.
- `code` changes only on the transition into BLANK (or into SHOW when BLANK=0). It is stable throughout each lit period.
- Commit latency:
  - OFF: `commit_ack` one cycle after `commit`.
  - Scanning: at most one frame period.
- `digit_sel` is never multi-hot. With BLANK≥1, no two digits are lit within BLANK cycles of each other.

## Test plan
Parameters for all scenarios: DIGITS=4, DWELL=4, BLANK=2.
- Reset/idle: assert `rst_n`=0 mid-SHOW → all outputs 0 immediately. Release with `enable`=0 for 20 cycles → `digit_sel`=0, `seg_en`=0 throughout.
- Scan order: write 1,2,3,4 to slots 0..3, commit in OFF → `commit_ack` next cycle. Then enable:
  - `digit_sel` sequence 0001,0010,0100,1000, each lit 4 cycles after 2 blank cycles.
  - `code` = 1,2,3,4 respectively.
  - `frame_start` every 24 cycles.
- Tear-free update: while digit 1 is lit, write slot 0=9 and slot 3=7, then commit:
  - remainder of the frame still shows 3 and 4;
  - `commit_ack` pulses at the wrap;
  - next frame shows 9,2,3,7.
- Collision: write slot 2=5 on the exact wrap edge with a commit pending → active[2] keeps its old value. A second commit applies 5 one frame later.
- Disable mid-dwell: drop `enable` during digit 2 SHOW → next cycle `digit_sel`=0. Re-enable → digit 0 lit after 2 blank cycles.
- Bad address: write `wr_addr`=3 is accepted. Simultaneous double `commit` → single `commit_ack`.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner
//
// Time-multiplexes one shared 4-bit-to-seven-segment decoder across DIGITS
// common-cathode digits. The host writes digit codes into a shadow copy. A
// commit copies the shadow into the active copy, and the scanner displays the
// active copy. That copy only happens while the scanner is off, or on the edge
// that wraps the digit index back to 0. A multi-digit update therefore never
// shows a mix of old and new codes within one frame.
//
// Each digit period is BLANK all-off cycles followed by DWELL lit cycles.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   enable       scanning runs while high; low forces OFF at the next edge
//   wr_en        write wr_data into shadow slot wr_addr (slots >= DIGITS ignored)
//   commit       request a shadow -> active transfer
//   commit_ack   one-cycle pulse on the cycle after the transfer edge
//   code         digit code presented to the decoder
//   seg_en       segment enable (ANDed with the decoder outputs elsewhere)
//   digit_sel    one-hot digit drive, active high
//   frame_start  one-cycle pulse on the first lit cycle of digit 0
//
// All outputs are registered.
module display_scanner #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_addr,
    input  logic [3:0]                wr_data,
    input  logic                      commit,
    output logic                      commit_ack,
    output logic [3:0]                code,
    output logic                      seg_en,
    output logic [DIGITS-1:0]         digit_sel,
    output logic                      frame_start
);

    localparam int IW   = $clog2(DIGITS);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic [CW-1:0]           cnt_q;
    logic                    pending_q;
    logic [DIGITS-1:0][3:0]  shadow_q;
    logic [DIGITS-1:0][3:0]  active_q;
    logic [DIGITS-1:0][3:0]  active_d;
    logic                    commit_ack_q;
    logic [3:0]              code_q;
    logic                    seg_en_q;
    logic [DIGITS-1:0]       digit_sel_q;
    logic                    frame_start_q;

    logic                    wr_ok;
    logic                    dwell_done;
    logic                    blank_done;
    logic                    wrap;
    logic                    xfer;
    logic [IW-1:0]           idx_inc;

    function automatic logic [DIGITS-1:0] onehot(input logic [IW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    assign wr_ok      = wr_en && (32'(wr_addr) < DIGITS);
    assign dwell_done = (cnt_q == CW'(DWELL - 1));
    assign blank_done = (cnt_q == CW'(BLANK - 1));
    assign idx_inc    = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    // Frame boundary: last lit cycle of the last digit, scanning continues.
    // A disable on that same edge goes to OFF instead; OFF then transfers.
    assign wrap = enable && (state_q == S_SHOW) && dwell_done
               && (idx_q == IW'(DIGITS - 1));
    assign xfer = pending_q && ((state_q == S_OFF) || wrap);

    // Active copy as it will be after this edge. Used so that the code loaded
    // on the transfer edge already reflects the new frame's contents.
    assign active_d = xfer ? shadow_q : active_q;

    // Digit storage and commit handshake. On a write/transfer collision the
    // transfer takes the pre-write shadow value. A commit on the transfer
    // edge re-arms pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (wr_ok) shadow_q[wr_addr] <= wr_data;
            if (xfer)  active_q <= shadow_q;
            pending_q <= commit | (pending_q & ~xfer);
        end
    end

    // Scan FSM with registered outputs. code is loaded only when a new digit
    // period starts, so it is stable for the whole blank + lit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_OFF;
            idx_q         <= '0;
            cnt_q         <= '0;
            commit_ack_q  <= 1'b0;
            code_q        <= 4'd0;
            seg_en_q      <= 1'b0;
            digit_sel_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            commit_ack_q  <= xfer;
            frame_start_q <= 1'b0;
            if (!enable) begin
                state_q     <= S_OFF;
                idx_q       <= '0;
                cnt_q       <= '0;
                seg_en_q    <= 1'b0;
                digit_sel_q <= '0;
            end else begin
                case (state_q)
                    S_OFF: begin
                        idx_q  <= '0;
                        cnt_q  <= '0;
                        code_q <= active_d[0];
                        if (BLANK > 0) begin
                            state_q <= S_BLANK;
                        end else begin
                            state_q       <= S_SHOW;
                            seg_en_q      <= 1'b1;
                            digit_sel_q   <= onehot('0);
                            frame_start_q <= 1'b1;
                        end
                    end
                    S_BLANK: begin
                        if (blank_done) begin
                            state_q       <= S_SHOW;
                            cnt_q         <= '0;
                            seg_en_q      <= 1'b1;
                            digit_sel_q   <= onehot(idx_q);
                            frame_start_q <= (idx_q == '0);
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_SHOW: begin
                        if (dwell_done) begin
                            cnt_q  <= '0;
                            idx_q  <= idx_inc;
                            code_q <= active_d[idx_inc];
                            if (BLANK > 0) begin
                                state_q     <= S_BLANK;
                                seg_en_q    <= 1'b0;
                                digit_sel_q <= '0;
                            end else begin
                                state_q       <= S_SHOW;
                                digit_sel_q   <= onehot(idx_inc);
                                frame_start_q <= (idx_inc == '0);
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= S_OFF;
                        seg_en_q    <= 1'b0;
                        digit_sel_q <= '0;
                    end
                endcase
            end
        end
    end

    assign commit_ack  = commit_ack_q;
    assign code        = code_q;
    assign seg_en      = seg_en_q;
    assign digit_sel   = digit_sel_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner with DIGITS=4, DWELL=4, BLANK=2 (frame = 24 cycles).
// A reference model tracks time since enable and derives the expected outputs
// from frame position arithmetic. It also models the shadow/active copies and
// the pending commit flag.
module tb_display_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;
    logic       commit_ack;
    logic [3:0] code;
    logic       seg_en;
    logic [3:0] digit_sel;
    logic       frame_start;

    int n_chk  = 0;
    int n_fail = 0;

    display_scanner #(.DIGITS(4), .DWELL(4), .BLANK(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .commit_ack  (commit_ack),
        .code        (code),
        .seg_en      (seg_en),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit         m_on;
    int         t;
    logic [3:0] m_sh [4];
    logic [3:0] m_ac [4];
    bit         m_pend;
    bit         m_ack;
    logic [3:0] m_code;

    task automatic model_reset();
        m_on = 0; t = 0; m_pend = 0; m_ack = 0; m_code = 4'd0;
        for (int i = 0; i < 4; i++) begin
            m_sh[i] = 4'd0;
            m_ac[i] = 4'd0;
        end
    endtask

    // Applies the inputs sampled at the edge just taken.
    task automatic model_step();
        bit xf;
        xf = m_pend && (!m_on || (enable && ((t + 1) % 24 == 0)));
        if (xf) m_ac = m_sh;
        m_ack  = xf;
        m_pend = commit || (m_pend && !xf);
        if (wr_en) m_sh[wr_addr] = wr_data;
        if (!enable)    m_on = 0;
        else if (!m_on) begin m_on = 1; t = 0; end
        else            t++;
        if (m_on) m_code = m_ac[(t % 24) / 6];
    endtask

    function automatic logic [10:0] exp_vec();
        logic       lit;
        logic [3:0] sel;
        lit = m_on && ((t % 6) >= 2);
        sel = lit ? (4'b0001 << ((t % 24) / 6)) : 4'b0000;
        return {m_code, lit, sel, (m_on && (t % 24 == 2)), m_ack};
    endfunction

    function automatic logic [10:0] act_vec();
        return {code, seg_en, digit_sel, frame_start, commit_ack};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while (!(m_on && (t % 24 == ph)) && k < 100) begin tick(); k++; end
        if (!(m_on && (t % 24 == ph))) begin
            n_chk++; n_fail++;
            $display("FAIL wait_phase: phase %0d not reached, t=%0d", ph, t);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 0; wr_en = 0; wr_addr = 0; wr_data = 0; commit = 0;
        model_reset();
        #23 rst_n = 1'b1;
        tick();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_prescan: got %h expected %h", act_vec(), exp_vec());
            end
        end
        // Mid-SHOW now (t=3): asynchronous reset clears outputs immediately.
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (act_vec() !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 000", act_vec());
        end
        model_reset();
        enable = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_chk++;
            if (seg_en !== 1'b0 || digit_sel !== 4'b0000 || act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle: got %h expected %h", act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_scan_order();
        logic [3:0] exp_sel [4];
        logic [3:0] exp_cd  [4];
        logic [3:0] prev_sel;
        int         nseq, nlit, fs_t[$];
        exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_cd  = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; wr_addr = 2'(i); wr_data = 4'(i + 1);
            tick();
        end
        wr_en = 0; commit = 1;
        tick();
        commit = 0;
        n_chk++;
        if (commit_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL off_commit_early: got %b expected 0", commit_ack);
        end
        tick();
        n_chk++;
        if (commit_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL off_commit_ack: got %b expected 1", commit_ack);
        end
        enable = 1;
        prev_sel = 4'b0000; nseq = 0; nlit = 0;
        for (int k = 0; k < 48; k++) begin
            tick();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL scan_model: t=%0d got %h expected %h", t, act_vec(), exp_vec());
            end
            if (seg_en) nlit++;
            if (frame_start) fs_t.push_back(k);
            if (digit_sel != 4'b0000 && prev_sel == 4'b0000) begin
                n_chk++;
                if (digit_sel !== exp_sel[nseq % 4] || code !== exp_cd[nseq % 4] || (k % 6) != 2) begin
                    n_fail++;
                    $display("FAIL scan_seq: k=%0d got sel %b code %0d expected sel %b code %0d",
                             k, digit_sel, code, exp_sel[nseq % 4], exp_cd[nseq % 4]);
                end
                nseq++;
            end
            prev_sel = digit_sel;
        end
        n_chk++;
        if (nlit != 32 || nseq != 8) begin
            n_fail++;
            $display("FAIL scan_counts: got lit %0d digits %0d expected 32 8", nlit, nseq);
        end
        n_chk++;
        if (fs_t.size() != 2 || fs_t[0] != 2 || fs_t[1] != 26) begin
            n_fail++;
            $display("FAIL frame_start_period: got %0d pulses expected 2 at 2,26", fs_t.size());
        end
    endtask

    task automatic test_tear_free();
        logic [3:0] got[$];
        logic [3:0] expc [6];
        int         acks, ack_ph;
        expc = '{4'd3, 4'd4, 4'd9, 4'd2, 4'd3, 4'd7};
        wait_phase(8);
        wr_en = 1; wr_addr = 0; wr_data = 9; tick();
        wr_addr = 3; wr_data = 7; tick();
        wr_en = 0; commit = 1; tick();
        commit = 0;
        acks = 0; ack_ph = -1;
        while (got.size() < 6 && acks < 5) begin
            tick();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL tear_model: t=%0d got %h expected %h", t, act_vec(), exp_vec());
            end
            if (commit_ack) begin acks++; ack_ph = t % 24; end
            if (seg_en && (t % 6 == 2)) got.push_back(code);
        end
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (got[i] !== expc[i]) begin
                n_fail++;
                $display("FAIL tear_code[%0d]: got %0d expected %0d", i, got[i], expc[i]);
            end
        end
        n_chk++;
        if (acks != 1 || ack_ph != 0) begin
            n_fail++;
            $display("FAIL tear_ack: got %0d acks at phase %0d expected 1 at 0", acks, ack_ph);
        end
    endtask

    task automatic test_collision();
        logic [3:0] got[$];
        bit         recommitted;
        wait_phase(10);
        commit = 1; tick(); commit = 0;
        wait_phase(23);
        wr_en = 1; wr_addr = 2; wr_data = 5;
        tick();
        wr_en = 0;
        n_chk++;
        if (commit_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_ack: got %b expected 1", commit_ack);
        end
        recommitted = 0;
        for (int k = 0; k < 80 && got.size() < 2; k++) begin
            if (got.size() == 1 && !recommitted) begin commit = 1; recommitted = 1; end
            else commit = 0;
            tick();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL collision_model: t=%0d got %h expected %h", t, act_vec(), exp_vec());
            end
            if (seg_en && (t % 24 == 14)) got.push_back(code);
        end
        commit = 0;
        n_chk++;
        if (got.size() != 2 || got[0] !== 4'd3 || got[1] !== 4'd5) begin
            n_fail++;
            $display("FAIL collision_codes: got %p expected 3 then 5", got);
        end
    endtask

    task automatic test_disable();
        wait_phase(15);
        enable = 0;
        tick();
        n_chk++;
        if (digit_sel !== 4'b0000 || seg_en !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_off: got sel %b seg %b expected 0000 0", digit_sel, seg_en);
        end
        tick(); tick();
        enable = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (digit_sel !== ((i == 2) ? 4'b0001 : 4'b0000) || act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reenable[%0d]: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        n_chk++;
        if (code !== 4'd9) begin
            n_fail++;
            $display("FAIL reenable_code: got %0d expected 9", code);
        end
    endtask

    task automatic test_back_to_back();
        int         acks;
        logic [3:0] d3;
        wr_en = 1; wr_addr = 3; wr_data = 4'hA; tick(); wr_en = 0;
        wait_phase(4);
        commit = 1; tick(); tick(); commit = 0;
        acks = 0; d3 = 4'hF;
        for (int k = 0; k < 50; k++) begin
            tick();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_model: t=%0d got %h expected %h", t, act_vec(), exp_vec());
            end
            if (commit_ack) acks++;
            if (acks == 1 && seg_en && (t % 24 == 20)) d3 = code;
        end
        n_chk++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL double_commit_ack: got %0d acks expected 1", acks);
        end
        n_chk++;
        if (d3 !== 4'hA) begin
            n_fail++;
            $display("FAIL addr3_write: got %h expected a", d3);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            enable  = ($urandom_range(99) < 3) ? ~enable : enable;
            wr_en   = ($urandom_range(99) < 30);
            wr_addr = 2'($urandom_range(3));
            wr_data = 4'($urandom_range(15));
            commit  = ($urandom_range(99) < 8);
            tick();
            n_chk++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random: k=%0d t=%0d got %h expected %h", k, t, act_vec(), exp_vec());
            end
        end
        wr_en = 0; commit = 0;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_collision();
        test_disable();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
